// File: rtl/router_fifo_pkg.sv
// Shared definitions for the router FIFO read-side logic.
//   RDR_BUF_DEPTH : number of entries in the reader output buffer
//   RDR_PTR_W     : width of the buffer read/write pointers
//   rdr_ptr_t     : buffer pointer type
//   rdr_ptr_inc() : pointer increment that wraps from the last entry back to 0
package router_fifo_pkg;

    localparam int unsigned RDR_BUF_DEPTH = 3;
    localparam int unsigned RDR_PTR_W     = 2;

    typedef logic [RDR_PTR_W-1:0] rdr_ptr_t;

    // Advance a buffer pointer; depth is not a power of two, so wrap explicitly.
    function automatic rdr_ptr_t rdr_ptr_inc(input rdr_ptr_t ptr);
        rdr_ptr_t nxt;
        if (ptr == RDR_PTR_W'(RDR_BUF_DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + RDR_PTR_W'(1);
        end
        return nxt;
    endfunction

endpackage : router_fifo_pkg

// File: rtl/fifo_reader_obuf.sv
// 3-entry circular output buffer for the FIFO stream reader.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset; clears pointers, count and entries
//   push_i       : write push_data_i at the write pointer (caller guarantees a free slot)
//   push_data_i  : word to store
//   pop_i        : retire the head entry (caller guarantees the buffer is non-empty)
//   head_o       : entry at the read pointer
//   count_o      : number of entries held, 0..3
module fifo_reader_obuf
    import router_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [RDR_BUF_DEPTH];
    rdr_ptr_t         wr_ptr_q, wr_ptr_d;
    rdr_ptr_t         rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    // Pointer and occupancy next-state; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push_i) begin
            wr_ptr_d = rdr_ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = rdr_ptr_inc(rd_ptr_q);
        end

        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State and storage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < RDR_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule : fifo_reader_obuf

// File: rtl/fifo_stream_reader.sv
// Read-side master for a normal-mode (1-cycle latency) scfifo. Issues rdreq only when
// a landing slot is guaranteed, buffers returned words and presents them as a
// valid/ready stream. rdreq depends on registered state and fifo_empty only, never
// on out_ready.
// Ports:
//   clock       : clock, rising edge
//   sclr        : synchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_q      : FIFO read data, valid the cycle after an accepted rdreq
//   fifo_rdreq  : FIFO read request
//   out_valid   : output word available
//   out_data    : output word (buffer head)
//   out_ready   : downstream accepts the word
//   buf_level   : words held in the buffer, 0..3
//   xfer_count  : saturating count of output handshakes
module fifo_stream_reader
    import router_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_q,
    output logic                 fifo_rdreq,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           buf_level,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic [1:0]           buf_cnt;
    logic [2:0]           owed;
    logic                 pop;

    // Slots already committed: buffered words plus the word currently in flight.
    assign owed       = {1'b0, buf_cnt} + {2'b00, inflight_q};
    assign fifo_rdreq = !sclr && !fifo_empty && (owed < 3'(RDR_BUF_DEPTH));

    assign out_valid  = (buf_cnt != 2'd0);
    assign pop        = out_valid && out_ready;

    fifo_reader_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk_i       (clock),
        .rst_i       (sclr),
        .push_i      (inflight_q),
        .push_data_i (fifo_q),
        .pop_i       (pop),
        .head_o      (out_data),
        .count_o     (buf_cnt)
    );

    // Handshake counter, held at all-ones once saturated.
    always_comb begin
        xfer_d = xfer_q;
        if (pop && (xfer_q != '1)) begin
            xfer_d = xfer_q + CNT_WIDTH'(1);
        end
    end

    // An accepted read lands next cycle; sclr discards any word still in flight.
    always_ff @(posedge clock) begin
        if (sclr) begin
            inflight_q <= 1'b0;
            xfer_q     <= '0;
        end else begin
            inflight_q <= fifo_rdreq;
            xfer_q     <= xfer_d;
        end
    end

    assign buf_level  = buf_cnt;
    assign xfer_count = xfer_q;

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: models the upstream scfifo as a queue
// and predicts the stream as "words taken from the FIFO but not yet handed out".
module tb_fifo_stream_reader;

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 5;
    localparam int          XMAX = 31;

    logic          clock;
    logic          sclr;
    logic          fifo_empty;
    logic [W-1:0]  fifo_q;
    logic          fifo_rdreq;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    buf_level;
    logic [CW-1:0] xfer_count;

    fifo_stream_reader #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .sclr       (sclr),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .buf_level  (buf_level),
        .xfer_count (xfer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Upstream FIFO contents and the reference model state.
    logic [W-1:0] fq[$];
    logic [W-1:0] held[$];   // words read from the FIFO, not yet handed out
    int           inflight_m = 0;
    int           xfer_m     = 0;
    bit           hs_seen, rd_seen;
    logic [W-1:0] hs_act, hs_exp;

    task automatic push_word(input logic [W-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample the pre-edge handshake/read, update FIFO and model after the edge.
    task automatic tick();
        logic         rd, hs, rst;
        logic [W-1:0] d;
        rd  = fifo_rdreq;
        hs  = out_valid && out_ready;
        rst = sclr;
        d   = out_data;
        @(posedge clock);
        #1;
        hs_seen = 1'b0;
        rd_seen = rd;
        if (rd) begin
            if (fq.size() > 0) fifo_q = fq.pop_front();
            else fifo_q = 32'hBAD0BAD0;
        end
        if (rst) begin
            held.delete();
            inflight_m = 0;
            xfer_m     = 0;
        end else begin
            if (hs) begin
                hs_seen = 1'b1;
                hs_act  = d;
                if (held.size() > 0) hs_exp = held.pop_front();
                else hs_exp = 32'hEEEEEEEE;
                if (xfer_m != XMAX) xfer_m++;
            end
            if (rd) held.push_back(fifo_q);
            inflight_m = rd ? 1 : 0;
        end
        fifo_empty = (fq.size() == 0);
        #1;
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        out_ready = 1'b0;
        fifo_q = '0;
        fifo_empty = 1'b1;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (fifo_rdreq !== 1'b0) begin tests_failed++; $display("FAIL reset_rdreq cyc%0d got %b want 0", c, fifo_rdreq); end
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid cyc%0d got %b want 0", c, out_valid); end
            tests_run++;
            if (buf_level !== 2'd0) begin tests_failed++; $display("FAIL reset_level cyc%0d got %0d want 0", c, buf_level); end
            tests_run++;
            if (xfer_count !== '0) begin tests_failed++; $display("FAIL reset_xfer cyc%0d got %0d want 0", c, xfer_count); end
            tests_run++;
            if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data cyc%0d got %h want 0", c, out_data); end
        end
        // The upstream FIFO is cleared by the same sclr.
        fq.delete();
        fifo_empty = 1'b1;
        sclr = 1'b0;
        tick();
        tests_run++;
        if (fifo_rdreq !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle rdreq=%b valid=%b want 0/0", fifo_rdreq, out_valid);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_word(32'hA5A5A5A5);
        #1;
        tests_run++;
        if (fifo_rdreq !== 1'b1) begin tests_failed++; $display("FAIL single_rdreq_T got %b want 1", fifo_rdreq); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || fifo_rdreq !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_T1 valid=%b rdreq=%b want 0/0", out_valid, fifo_rdreq);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL single_T2 valid=%b data=%h want 1/a5a5a5a5", out_valid, out_data);
        end
        tick();
        tests_run++;
        if (!hs_seen || hs_act !== hs_exp) begin
            tests_failed++;
            $display("FAIL single_hs seen=%b data=%h want %h", hs_seen, hs_act, hs_exp);
        end
        tests_run++;
        if (xfer_count !== 5'd1) begin tests_failed++; $display("FAIL single_xfer got %0d want 1", xfer_count); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained valid=%b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        int got     = 0;
        bit started = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(32'(i));
        #1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            tick();
            if (hs_seen) begin
                tests_run++;
                if (hs_act !== 32'(got) || hs_exp !== 32'(got)) begin
                    tests_failed++;
                    $display("FAIL stream_data idx%0d got %h want %h", got, hs_act, 32'(got));
                end
                got++;
                started = 1'b1;
            end else if (started) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stream_bubble after %0d words got no handshake want handshake", got);
            end
        end
        tests_run++;
        if (got != 16) begin tests_failed++; $display("FAIL stream_count got %0d want 16", got); end
        tests_run++;
        if (xfer_count !== 5'd17) begin tests_failed++; $display("FAIL stream_xfer got %0d want 17", xfer_count); end
        tests_run++;
        if (out_valid !== 1'b0 || buf_level !== 2'd0) begin
            tests_failed++;
            $display("FAIL stream_drained valid=%b level=%0d want 0/0", out_valid, buf_level);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w[8];
        int reads = 0;
        int got   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = $urandom;
            push_word(w[i]);
        end
        #1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rd_seen) reads++;
            if (out_valid) begin
                tests_run++;
                if (out_data !== w[0]) begin
                    tests_failed++;
                    $display("FAIL bp_stable cyc%0d got %h want %h", c, out_data, w[0]);
                end
            end
        end
        tests_run++;
        if (reads != 3) begin tests_failed++; $display("FAIL bp_reads got %0d want 3", reads); end
        tests_run++;
        if (buf_level !== 2'd3) begin tests_failed++; $display("FAIL bp_level got %0d want 3", buf_level); end
        tests_run++;
        if (fifo_rdreq !== 1'b0) begin tests_failed++; $display("FAIL bp_rdreq_full got %b want 0", fifo_rdreq); end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            tick();
            if (hs_seen) begin
                tests_run++;
                if (hs_act !== w[got]) begin
                    tests_failed++;
                    $display("FAIL bp_order idx%0d got %h want %h", got, hs_act, w[got]);
                end
                got++;
            end
        end
        tests_run++;
        if (got != 8) begin tests_failed++; $display("FAIL bp_count got %0d want 8", got); end
        tests_run++;
        if (xfer_count !== 5'(xfer_m)) begin tests_failed++; $display("FAIL bp_xfer got %0d want %0d", xfer_count, xfer_m); end
    endtask

    task automatic test_inflight_empty();
        logic [W-1:0] w;
        w = $urandom;
        out_ready = 1'b0;
        push_word(w);
        #1;
        tick();
        tests_run++;
        if (rd_seen !== 1'b1) begin tests_failed++; $display("FAIL ie_read got %b want 1", rd_seen); end
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (fifo_rdreq !== 1'b0) begin tests_failed++; $display("FAIL ie_no_rdreq cyc%0d got %b want 0", c, fifo_rdreq); end
            tick();
        end
        tests_run++;
        if (buf_level !== 2'd1 || out_valid !== 1'b1 || out_data !== w) begin
            tests_failed++;
            $display("FAIL ie_landed level=%0d valid=%b data=%h want 1/1/%h", buf_level, out_valid, out_data, w);
        end
        out_ready = 1'b1;
        #1;
        tick();
        tests_run++;
        if (!hs_seen || hs_act !== w) begin
            tests_failed++;
            $display("FAIL ie_hs seen=%b data=%h want %h", hs_seen, hs_act, w);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] n[2];
        int got = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'hDEAD0000 + 32'(i));
        #1;
        repeat (3) tick();
        tests_run++;
        if (buf_level !== 2'd2 || rd_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL rm_setup level=%0d inflight=%b want 2/1", buf_level, rd_seen);
        end
        sclr = 1'b1;
        #1;
        tests_run++;
        if (fifo_rdreq !== 1'b0) begin tests_failed++; $display("FAIL rm_rdreq_in_sclr got %b want 0", fifo_rdreq); end
        tick();
        fq.delete();
        fifo_empty = 1'b1;
        sclr = 1'b0;
        #1;
        tests_run++;
        if (buf_level !== 2'd0) begin tests_failed++; $display("FAIL rm_level got %0d want 0", buf_level); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid got %b want 0", out_valid); end
        tests_run++;
        if (xfer_count !== '0) begin tests_failed++; $display("FAIL rm_xfer got %0d want 0", xfer_count); end
        n[0] = 32'h600D0000;
        n[1] = 32'h600D0001;
        push_word(n[0]);
        push_word(n[1]);
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (hs_seen) begin
                tests_run++;
                if (got >= 2 || hs_act !== n[got]) begin
                    tests_failed++;
                    $display("FAIL rm_after idx%0d got %h want %h", got, hs_act, (got < 2) ? n[got] : 32'hFFFFFFFF);
                end
                got++;
            end
        end
        tests_run++;
        if (got != 2) begin tests_failed++; $display("FAIL rm_count got %0d want 2", got); end
    endtask

    task automatic test_random();
        int thresh = 50;
        int exp_level;
        for (int c = 0; c < 500; c++) begin
            if (c % 50 == 0) thresh = $urandom_range(10, 100);
            if ($urandom_range(0, 3) != 0 && fq.size() < 8) push_word($urandom);
            out_ready = ($urandom_range(0, 99) < thresh);
            #1;
            exp_level = held.size() - inflight_m;
            tests_run++;
            if (fifo_rdreq !== (!fifo_empty && held.size() < 3)) begin
                tests_failed++;
                $display("FAIL rnd_rdreq cyc%0d got %b want %b", c, fifo_rdreq, (!fifo_empty && held.size() < 3));
            end
            tests_run++;
            if (buf_level !== 2'(exp_level) || out_valid !== (exp_level != 0)) begin
                tests_failed++;
                $display("FAIL rnd_level cyc%0d level=%0d valid=%b want %0d", c, buf_level, out_valid, exp_level);
            end
            if (exp_level != 0) begin
                tests_run++;
                if (out_data !== held[0]) begin
                    tests_failed++;
                    $display("FAIL rnd_head cyc%0d got %h want %h", c, out_data, held[0]);
                end
            end
            tests_run++;
            if (xfer_count !== 5'(xfer_m)) begin
                tests_failed++;
                $display("FAIL rnd_xfer cyc%0d got %0d want %0d", c, xfer_count, xfer_m);
            end
            tick();
            if (hs_seen) begin
                tests_run++;
                if (hs_act !== hs_exp) begin
                    tests_failed++;
                    $display("FAIL rnd_hs cyc%0d got %h want %h", c, hs_act, hs_exp);
                end
            end
        end
        tests_run++;
        if (xfer_count !== 5'd31) begin tests_failed++; $display("FAIL rnd_saturate got %0d want 31", xfer_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_inflight_empty();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule : tb_fifo_stream_reader
